// File: rtl/tbcs_2_if.sv
// Bus bundle for one 2-bit magnitude-comparator slice: operands, cascade
// inputs/outputs and the registered result with its qualifier.
interface tbcs_2_if;
    logic [1:0] a;
    logic [1:0] b;
    logic       e_in;
    logic       g_in;
    logic       in_valid;
    logic       eq_c;
    logic       gt_c;
    logic       eq;
    logic       gt;
    logic       lt;
    logic       out_valid;

    modport master (
        output a, b, e_in, g_in, in_valid,
        input  eq_c, gt_c, eq, gt, lt, out_valid
    );

    modport slave (
        input  a, b, e_in, g_in, in_valid,
        output eq_c, gt_c, eq, gt, lt, out_valid
    );
endinterface

// File: rtl/tbcs_2.sv
// Cascadable 2-bit unsigned magnitude-comparator slice. The cascade outputs are
// combinational; a qualified copy of the decision is registered with 1-cycle latency.
module tbcs_2 (
    input logic     clk,
    input logic     rst,
    tbcs_2_if.slave bus
);

    logic eq_c;
    logic gt_c;
    logic eq_d, eq_q;
    logic gt_d, gt_q;
    logic lt_d, lt_q;
    logic out_valid_d, out_valid_q;

    // A decided "greater" upstream dominates; a decided "less" upstream (e_in=0)
    // leaves both cascade outputs low, which downstream reads as "less".
    always_comb begin
        gt_c = bus.g_in | (bus.e_in & (bus.a > bus.b));
        eq_c = bus.e_in & ~bus.g_in & (bus.a == bus.b);

        eq_d        = eq_q;
        gt_d        = gt_q;
        lt_d        = lt_q;
        out_valid_d = 1'b0;
        if (bus.in_valid) begin
            eq_d        = eq_c;
            gt_d        = gt_c;
            lt_d        = ~eq_c & ~gt_c;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            lt_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            lt_q        <= lt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.eq_c      = eq_c;
    assign bus.gt_c      = gt_c;
    assign bus.eq        = eq_q;
    assign bus.gt        = gt_q;
    assign bus.lt        = lt_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_tbcs_2.sv
// Four tbcs_2 slices chained MSB-first into an 8-bit comparator, checked against
// an integer-level model of the comparison and of the registered result.
module tb_tbcs_2;

    logic clk = 1'b0;
    logic rst;

    tbcs_2_if if3 ();
    tbcs_2_if if2 ();
    tbcs_2_if if1 ();
    tbcs_2_if if0 ();

    tbcs_2 dut3 (.clk(clk), .rst(rst), .bus(if3));
    tbcs_2 dut2 (.clk(clk), .rst(rst), .bus(if2));
    tbcs_2 dut1 (.clk(clk), .rst(rst), .bus(if1));
    tbcs_2 dut0 (.clk(clk), .rst(rst), .bus(if0));

    assign if2.e_in = if3.eq_c;
    assign if2.g_in = if3.gt_c;
    assign if1.e_in = if2.eq_c;
    assign if1.g_in = if2.gt_c;
    assign if0.e_in = if1.eq_c;
    assign if0.g_in = if1.gt_c;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected registered state of the head slice (index 0) and the tail slice (index 1).
    logic exp_eq [2];
    logic exp_gt [2];
    logic exp_lt [2];
    logic exp_ov [2];

    // Decision of a comparison given upstream context: returns {greater, equal}.
    function automatic logic [1:0] decide(int unsigned x, int unsigned y, logic e, logic g);
        if (g)      return 2'b10;
        if (!e)     return 2'b00;
        if (x > y)  return 2'b10;
        if (x == y) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [7:0] av, input logic [7:0] bv,
                        input logic e, input logic g, input logic v, input logic r);
        logic [1:0] head_res;
        logic [1:0] full_res;
        logic [1:0] res [2];
        @(negedge clk);
        rst          = r;
        if3.a        = av[7:6];  if3.b = bv[7:6];
        if2.a        = av[5:4];  if2.b = bv[5:4];
        if1.a        = av[3:2];  if1.b = bv[3:2];
        if0.a        = av[1:0];  if0.b = bv[1:0];
        if3.e_in     = e;
        if3.g_in     = g;
        if3.in_valid = v;
        if2.in_valid = v;
        if1.in_valid = v;
        if0.in_valid = v;
        #1;
        head_res = decide(int'(av[7:6]), int'(bv[7:6]), e, g);
        full_res = decide(int'(av), int'(bv), e, g);
        check("head_gt_c", if3.gt_c, head_res[1]);
        check("head_eq_c", if3.eq_c, head_res[0]);
        check("chain_gt_c", if0.gt_c, full_res[1]);
        check("chain_eq_c", if0.eq_c, full_res[0]);
        res[0] = head_res;
        res[1] = full_res;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                exp_eq[k] = 1'b0; exp_gt[k] = 1'b0; exp_lt[k] = 1'b0; exp_ov[k] = 1'b0;
            end else if (v) begin
                exp_gt[k] = res[k][1];
                exp_eq[k] = res[k][0];
                exp_lt[k] = ~res[k][1] & ~res[k][0];
                exp_ov[k] = 1'b1;
            end else begin
                exp_ov[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("head_eq", if3.eq, exp_eq[0]);
        check("head_gt", if3.gt, exp_gt[0]);
        check("head_lt", if3.lt, exp_lt[0]);
        check("head_out_valid", if3.out_valid, exp_ov[0]);
        check("chain_eq", if0.eq, exp_eq[1]);
        check("chain_gt", if0.gt, exp_gt[1]);
        check("chain_lt", if0.lt, exp_lt[1]);
        check("chain_out_valid", if0.out_valid, exp_ov[1]);
    endtask

    initial begin
        rst          = 1'b1;
        if3.e_in     = 1'b1;
        if3.g_in     = 1'b0;
        if3.a = '0; if3.b = '0; if2.a = '0; if2.b = '0;
        if1.a = '0; if1.b = '0; if0.a = '0; if0.b = '0;
        if3.in_valid = 1'b0; if2.in_valid = 1'b0;
        if1.in_valid = 1'b0; if0.in_valid = 1'b0;

        // reset, then the basic head/chain cases
        step(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        step(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'h80, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        // upstream overrides
        step(8'h00, 8'hC0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(8'hC0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        // decisions made in lower slices
        step(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'h12, 8'h13, 1'b1, 1'b0, 1'b1, 1'b0);
        step(8'hFF, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
        // hold with in_valid low keeps the last decision
        step(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h33, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
        // reset discards a coincident capture; first capture afterwards is normal
        step(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b1);
        step(8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h0F, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       re;
            logic       rg;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            re = ($urandom_range(0, 3) != 0);
            rg = ($urandom_range(0, 5) == 0);
            step(ra, rb, re, rg, 1'($urandom), ($urandom_range(0, 15) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tbcs_2.md
TBCS_2 -- requirements
Module: tbcs_2

Interface
REQ-001 clk  input  1  single rising-edge clock for all state.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 a  input  2  operand A slice, unsigned, a[1] is MSB.
REQ-004 b  input  2  operand B slice, unsigned, b[1] is MSB.
REQ-005 e_in  input  1  cascade "equal so far" from the next-more-significant slice; tie to 1 at the chain head.
REQ-006 g_in  input  1  cascade "A greater so far" from the next-more-significant slice; tie to 0 at the chain head.
REQ-007 in_valid  input  1  qualifies a, b, e_in and g_in for capture.
REQ-008 eq_c  output  1  combinational cascade equal, feeds e_in of the next-less-significant slice.
REQ-009 gt_c  output  1  combinational cascade greater, feeds g_in of the next-less-significant slice.
REQ-010 eq  output  1  registered equal result.
REQ-011 gt  output  1  registered A-greater result.
REQ-012 lt  output  1  registered A-less result.
REQ-013 out_valid  output  1  registered qualifier for eq/gt/lt.
REQ-014 The block SHALL have no parameters; the slice width is fixed at 2 bits.

Function
REQ-015 Cascade logic SHALL be purely combinational with no clock dependency.
  - gt_c = g_in OR (e_in AND a>b).
  - eq_c = e_in AND NOT g_in AND (a==b).
REQ-016 g_in=1 SHALL take priority over e_in.
  - With g_in=1: gt_c=1 and eq_c=0, regardless of e_in, a and b.
REQ-017 e_in=0 with g_in=0 (upper slices decided "less") SHALL force eq_c=0 and gt_c=0, regardless of a and b.
REQ-018 Magnitude comparison SHALL be unsigned on the 2-bit values 0..3.
REQ-019 On a rising clk with in_valid=1 and rst=0, the block SHALL register the captured values:
  - eq <= eq_c
  - gt <= gt_c
  - lt <= NOT eq_c AND NOT gt_c
  - out_valid <= 1
REQ-020 On a rising clk with in_valid=0 and rst=0, the block SHALL:
  - hold eq, gt and lt unchanged;
  - set out_valid to 0.
REQ-021 Registered-output latency SHALL be exactly 1 clock from the capturing edge.
REQ-022 Exactly one of eq, gt, lt SHALL be 1 whenever out_valid=1.
REQ-023 Four slices chained MSB-first (slice 3 feeds slice 0 through eq_c/gt_c) SHALL form an 8-bit comparator.
  - The comparator result appears on slice 0's eq_c/gt_c within the same cycle.

Reset
REQ-024 rst=1 at a rising clk SHALL set eq=0, gt=0, lt=0 and out_valid=0, overriding in_valid.
REQ-025 eq_c and gt_c SHALL NOT be affected by rst.
REQ-026 A capture coinciding with reset SHALL be discarded.
REQ-027 The first capture after rst deasserts SHALL follow REQ-019 normally.

Verification
REQ-028 Head slice, e_in=1, g_in=0, a=2'b00, b=2'b00, in_valid=1 -> eq_c=1, gt_c=0; next cycle eq=1, gt=0, lt=0, out_valid=1.
REQ-029 Head slice, e_in=1, g_in=0, a=2'b00, b=2'b10 -> eq_c=0, gt_c=0; registered lt=1.
REQ-030 Head slice, e_in=1, g_in=0, a=2'b10, b=2'b00 -> gt_c=1; registered gt=1.
REQ-031 Cascade overrides: g_in=1, e_in=1, a=0, b=3 -> gt_c=1, eq_c=0; e_in=0, g_in=0, a=3, b=0 -> eq_c=0, gt_c=0.
REQ-032 Four-slice chain, head e=1, g=0:
  - A=0, B=0 -> eq=1;
  - A=0, B=128 -> eq=0, gt=0;
  - A=128, B=0 -> gt=1.
REQ-033 Reset and hold: assert rst with in_valid=1 -> all registered outputs 0 next edge; deassert rst, then hold in_valid=0 -> out_valid=0 and eq/gt/lt held.
